dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target that services load/store requests issued by the core's load/store path, with one outstanding request at a time.
- Implements byte, half and word accesses (mem_access_type_e), byte-lane store merging, and load sign/zero extension.
- Reports misalignment and illegal size as error responses carrying a trap_cause_e code, so the core raises the trap.
- Sits between the core's memory stage and a word-organised synchronous RAM array held inside the block.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- WAIT_STATES, 1: extra cycles held in WAIT before responding; range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block accepts request this cycle
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  input  2  mem_access_type_e
- req_unsigned  input  1  load zero-extends when 1 (LBU/LHU)
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts response
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  request faulted
- rsp_cause  output  4  trap_cause_e; TRAP_NONE when rsp_err = 0

Behaviour:
- Interface: "one clock; reset is synchronous and active-high" (clk, rst).
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; rsp_cause=TRAP_NONE (4'b0000). Memory contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches all req_* fields. Goes to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: counter loads WAIT_STATES-1 and decrements to 0, then goes to RESP. req_ready=0.
  - RESP: rsp_valid=1; rsp_* stable until rsp_ready. Goes to IDLE on rsp_ready. req_ready=0.
- Latency: with WAIT_STATES=0, rsp_valid asserts in the cycle after acceptance. In general it asserts WAIT_STATES+1 cycles after acceptance.
- No back-to-back pipelining. A new request is accepted in the cycle after the response handshake.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap.
- Alignment checks:
  - HALF requires addr[0]=0.
  - WORD requires addr[1:0]=0.
  - Any violation: rsp_err=1, rsp_cause=TRAP_MEMORY_ADDRESS_MISALIGNED (4'b0110), no array write, rdata=0.
- req_size=2'b11: rsp_err=1, rsp_cause=TRAP_ILLEGAL_INSTRUCTION (4'b0101), no write.
- Store:
  - Byte enables: BYTE = 1<<addr[1:0]; HALF = 0011<<addr[1:0]; WORD = 1111.
  - Write data is replicated into lanes: byte ×4, half ×2.
  - Only enabled lanes change. The write commits exactly once, on the cycle of entering RESP.
- Load:
  - Array read happens on entering RESP.
  - Lane select by addr[1:0], then extension:
    - BYTE: sign-extend bit 7 unless req_unsigned.
    - HALF: sign-extend bit 15 unless req_unsigned.
    - WORD: unchanged; req_unsigned ignored.
- Read-after-write: a load accepted immediately after a store's response returns the stored data.
- rsp_ready held high in RESP: response lasts exactly one cycle.
- rsp_ready asserted outside RESP: ignored.
- rst mid-WAIT or mid-RESP: return to IDLE next cycle and drop the response.
  - A store whose write has already committed stays committed.
  - A store still in WAIT is not written.
- req_valid while not ready: ignored. The requester holds its fields until the handshake.

Decomposition:
- Package isa_shared additions:
  - typedef enum dmem_state_e {DMEM_IDLE, DMEM_WAIT, DMEM_RESP}.
  - Constant DMEM_SIZE_ILLEGAL = 2'b11.
- Reuse existing mem_access_type_e and trap_cause_e.
- Sub-module dmem_lane_align: combinational store lane replication/byte-enable generation plus load lane select/extension. Reusable by the core's LSU tests.
- Storage is an inferred word array with per-byte write enables, kept inside dmem_responder.

Test Plan:
- Store WORD 0x8000_0010 data 0xDEADBEEF, then load WORD same address -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_cause 0.
- Store BYTE addr 0x13 data 0x000000A5 over word 0x11223344, then load WORD 0x10 -> 0xA5223344. Load BYTE 0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5.
- Store HALF addr 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001; LHU -> 0x00008001; LW 0x20 -> upper half 0x8001, lower half unchanged.
- LW addr 0x06 -> rsp_err 1, rsp_cause 4'b0110, rdata 0. SH addr 0x05 -> same error, with a subsequent LW 0x04 showing the memory unchanged. req_size 2'b11 -> cause 4'b0101.
- Handshake/latency: WAIT_STATES=3 -> rsp_valid rises 4 cycles after acceptance. rsp_ready held low 5 cycles -> rsp_* stable and req_ready 0 throughout. req_ready returns to 1 the cycle after the rsp handshake.
- Reset during WAIT of a SW to 0x40 -> next cycle IDLE, rsp_valid 0, req_ready 1; later LW 0x40 returns the old value. Address wrap: DEPTH_WORDS=1024, SW 0x1000 aliases to 0x0000.

Source files
------------

// File: rtl/isa_shared.sv
// Shared ISA-level types: memory access sizes, trap causes, data-memory FSM states.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package isa_shared;

    // Load/store access width, encoded as the RISC-V funct3[1:0] size field
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_type_e;

    // Trap causes the core raises on a faulted access
    typedef enum logic [3:0] {
        TRAP_NONE                      = 4'b0000,
        TRAP_ILLEGAL_INSTRUCTION       = 4'b0101,
        TRAP_MEMORY_ADDRESS_MISALIGNED = 4'b0110
    } trap_cause_e;

    // Data-memory responder control states
    typedef enum logic [1:0] {
        DMEM_IDLE,
        DMEM_WAIT,
        DMEM_RESP
    } dmem_state_e;

    // The one size encoding that has no access width behind it
    localparam logic [1:0] DMEM_SIZE_ILLEGAL = 2'b11;

    // Outcome of checking an access request for faults
    typedef struct packed {
        logic        err;
        trap_cause_e cause;
    } dmem_fault_t;

    // Illegal size wins over misalignment, since alignment is meaningless without a width
    function automatic dmem_fault_t dmem_classify(input logic [1:0] size, input logic [1:0] addr_lo);
        dmem_fault_t f;
        f.err   = 1'b0;
        f.cause = TRAP_NONE;
        if (size == DMEM_SIZE_ILLEGAL) begin
            f.err   = 1'b1;
            f.cause = TRAP_ILLEGAL_INSTRUCTION;
        end else if (((size == MEM_HALF) && addr_lo[0]) ||
                     ((size == MEM_WORD) && (addr_lo != 2'b00))) begin
            f.err   = 1'b1;
            f.cause = TRAP_MEMORY_ADDRESS_MISALIGNED;
        end
        return f;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit word memory: store replication/enables and load select/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs in the same cycle.
module dmem_lane_align
    import isa_shared::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate right-aligned data into every lane, enable only the addressed lanes
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_size)
            MEM_BYTE: begin
                st_be        = 4'b0001 << st_addr_lo;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            MEM_HALF: begin
                st_be        = 4'b0011 << st_addr_lo;
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            MEM_WORD: begin
                st_be        = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: begin
                st_be        = 4'b0000;
                st_wdata_rep = st_wdata;
            end
        endcase
    end

    // Load side: pick the addressed lane, then sign- or zero-extend to 32 bits
    always_comb begin
        ld_byte = ld_word[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data = 32'h0;
        case (ld_size)
            MEM_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            MEM_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            MEM_WORD: ld_data = ld_word;
            default:  ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding load/store to an internal word RAM with fault reporting.
// Latency: rsp_valid rises WAIT_STATES+1 cycles after the request handshake.
// Backpressure: req_ready low from acceptance until the cycle after the rsp handshake; rsp held until rsp_ready.
module dmem_responder
    import isa_shared::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [3:0]  rsp_cause
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         AW        = IDX_W + 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    dmem_state_e state_q, state_d;
    logic [3:0]  wait_cnt_q;
    logic        accept;
    logic        enter_resp;

    // Request fields captured at the handshake; the requester may change its inputs afterwards
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [1:0]    lat_size;
    logic          lat_unsigned;

    // Fields of the access that commits this cycle: live inputs when going straight from IDLE
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_size;
    logic [IDX_W-1:0] cur_idx;
    dmem_fault_t   cur_fault;
    dmem_fault_t   rsp_fault;

    logic [3:0]  st_be;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;
    logic [31:0] rd_word_q;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid & req_ready;

    // Address bits above the array index alias onto the same words
    generate
        if (AW < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[31:AW];
        end
    endgenerate

    // Choose which copy of the request fields drives the commit
    always_comb begin
        if (state_q == DMEM_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr[AW-1:0];
            cur_wdata = req_wdata;
            cur_size  = req_size;
        end else begin
            cur_we    = lat_we;
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_size  = lat_size;
        end
    end

    assign cur_idx   = cur_addr[AW-1:2];
    assign cur_fault = dmem_classify(cur_size, cur_addr[1:0]);
    assign rsp_fault = dmem_classify(lat_size, lat_addr[1:0]);

    // Next state, handshake outputs and the single commit strobe
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = DMEM_WAIT;
                    end else begin
                        state_d    = DMEM_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            DMEM_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = DMEM_RESP;
                    enter_resp = 1'b1;
                end
            end
            DMEM_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = DMEM_IDLE;
                end
            end
            default: state_d = DMEM_IDLE;
        endcase
        // Reset aborts whatever is in flight; an uncommitted store never reaches the array
        if (rst) begin
            state_d    = DMEM_IDLE;
            enter_resp = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait-state down-counter, armed at acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else if (accept) begin
            wait_cnt_q <= WAIT_LOAD;
        end else if ((state_q == DMEM_WAIT) && (wait_cnt_q != 4'd0)) begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
        end
    end

    // Capture the request at the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= 32'h0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
        end else if (accept) begin
            lat_we       <= req_we;
            lat_addr     <= req_addr[AW-1:0];
            lat_wdata    <= req_wdata;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
        end
    end

    dmem_lane_align u_lane_align (
        .st_addr_lo   (cur_addr[1:0]),
        .st_size      (cur_size),
        .st_wdata     (cur_wdata),
        .st_be        (st_be),
        .st_wdata_rep (st_wdata_rep),
        .ld_addr_lo   (lat_addr[1:0]),
        .ld_size      (lat_size),
        .ld_unsigned  (lat_unsigned),
        .ld_word      (rd_word_q),
        .ld_data      (ld_data)
    );

    // Word array: read and byte-masked write both happen once, on the cycle of entering RESP
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            rd_word_q <= mem[cur_idx];
            if (cur_we && !cur_fault.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (st_be[b]) begin
                        mem[cur_idx][b*8 +: 8] <= st_wdata_rep[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Response fields come from captured state, so they hold steady while rsp_ready is low
    always_comb begin
        rsp_err   = (state_q == DMEM_RESP) && rsp_fault.err;
        rsp_cause = rsp_err ? rsp_fault.cause : TRAP_NONE;
        rsp_rdata = ((state_q == DMEM_RESP) && !lat_we && !rsp_fault.err) ? ld_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int WS = 3;
    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  rsp_cause;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] last_rdata;
    logic        last_err;
    logic [3:0]  last_cause;

    // Reference memory kept as plain bytes: byte address = word index * 4 + lane
    logic [7:0] ref_mem [DW*4];

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DW),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .rsp_cause    (rsp_cause)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Natural-alignment rule, byte-wise memory, extension by filling upper bytes
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic err, output logic [3:0] cause, output logic [31:0] rdata);
        int nb;
        int base;
        err   = 1'b0;
        cause = 4'd0;
        rdata = 32'h0;
        if (size == 2'd3) begin
            err   = 1'b1;
            cause = 4'd5;
            return;
        end
        nb = 1 << size;
        if ((addr % nb) != 0) begin
            err   = 1'b1;
            cause = 4'd6;
            return;
        end
        base = int'(((addr >> 2) % DW) * 4 + (addr % 4));
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rdata[8*i +: 8] = ref_mem[base + i];
            if (!uns && nb < 4 && rdata[8*nb - 1]) begin
                for (int i = nb; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    endtask

    // One full transaction: handshake, latency, optional hold with stability checks, response handshake
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int hold);
        logic        e_err;
        logic [3:0]  e_cause;
        logic [31:0] e_rdata;
        logic [31:0] s_rdata;
        logic [4:0]  s_ec;
        int n;
        wait_idle();
        model_access(we, addr, wdata, size, uns, e_err, e_cause, e_rdata);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        n = 0;
        while (!rsp_valid && n < 50) begin
            rsp_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 32'(n + 1), 32'(WS + 1));
        rsp_ready = 1'b0;
        s_rdata = rsp_rdata;
        s_ec    = {rsp_err, rsp_cause};
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", rsp_rdata, s_rdata);
            check_eq("hold_errcause", 32'({rsp_err, rsp_cause}), 32'(s_ec));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        check_eq("rsp_rdata", rsp_rdata, e_rdata);
        check_eq("rsp_err", 32'(rsp_err), 32'(e_err));
        check_eq("rsp_cause", 32'(rsp_cause), 32'(e_cause));
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        last_cause = rsp_cause;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'($urandom);
        check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check_eq("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        d_err;
        logic [3:0]  d_cause;
        logic [31:0] d_rdata;
        logic [31:0] a;
        int n;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_cause", 32'(rsp_cause), 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b0;

        // Give the 64 words used below known contents
        for (int w = 0; w < 64; w++) do_req(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 0);

        do_req(1'b1, 32'h8000_0010, 32'hDEADBEEF, 2'd2, 1'b0, 0);
        do_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 0);
        check_eq("tp_lw_deadbeef", last_rdata, 32'hDEADBEEF);
        check_eq("tp_lw_deadbeef_cause", 32'(last_cause), 32'd0);

        do_req(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, 1);
        do_req(1'b1, 32'h13, 32'h000000A5, 2'd0, 1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0);
        check_eq("tp_sb_merge", last_rdata, 32'hA5223344);
        do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0);
        check_eq("tp_lb", last_rdata, 32'hFFFFFFA5);
        do_req(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 2);
        check_eq("tp_lbu", last_rdata, 32'h000000A5);

        do_req(1'b1, 32'h20, 32'h13577531, 2'd2, 1'b0, 0);
        do_req(1'b1, 32'h22, 32'h00008001, 2'd1, 1'b0, 0);
        do_req(1'b0, 32'h22, 32'h0, 2'd1, 1'b0, 0);
        check_eq("tp_lh", last_rdata, 32'hFFFF8001);
        do_req(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 0);
        check_eq("tp_lhu", last_rdata, 32'h00008001);
        do_req(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0);
        check_eq("tp_sh_merge", last_rdata, 32'h80017531);

        do_req(1'b0, 32'h06, 32'h0, 2'd2, 1'b0, 0);
        check_eq("tp_lw_misal_err", 32'(last_err), 32'd1);
        check_eq("tp_lw_misal_cause", 32'(last_cause), 32'd6);
        check_eq("tp_lw_misal_rdata", last_rdata, 32'h0);
        do_req(1'b1, 32'h04, 32'h01020304, 2'd2, 1'b0, 0);
        do_req(1'b1, 32'h05, 32'h0000FFFF, 2'd1, 1'b0, 0);
        check_eq("tp_sh_misal_cause", 32'(last_cause), 32'd6);
        do_req(1'b0, 32'h04, 32'h0, 2'd2, 1'b0, 0);
        check_eq("tp_sh_misal_nowrite", last_rdata, 32'h01020304);
        do_req(1'b1, 32'h08, 32'hFFFFFFFF, 2'd3, 1'b0, 0);
        check_eq("tp_size3_cause", 32'(last_cause), 32'd5);

        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5);

        // Reset while a store is still waiting: it must never reach the array
        do_req(1'b1, 32'h40, 32'h12345678, 2'd2, 1'b0, 0);
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEBABE;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_wait_req_ready", 32'(req_ready), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0);
        check_eq("rst_wait_old_value", last_rdata, 32'h12345678);

        // Reset while the store's response is pending: the write already happened
        wait_idle();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h55AA55AA;
        req_size = 2'd2; req_unsigned = 1'b0;
        model_access(1'b1, 32'h44, 32'h55AA55AA, 2'd2, 1'b0, d_err, d_cause, d_rdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_resp_reached", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_resp_dropped", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 32'h44, 32'h0, 2'd2, 1'b0, 0);
        check_eq("rst_resp_committed", last_rdata, 32'h55AA55AA);

        do_req(1'b1, 32'h1000, 32'h0F0F1234, 2'd2, 1'b0, 0);
        do_req(1'b0, 32'h0000, 32'h0, 2'd2, 1'b0, 0);
        check_eq("wrap_alias", last_rdata, 32'h0F0F1234);

        // Random mix over the prefilled region, with occasional high address bits to exercise aliasing
        for (int t = 0; t < 300; t++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
            do_req(1'($urandom), a, $urandom,
                   ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
